// File: rtl/oam_dma_master.sv
// oam_dma_master: sprite OAM DMA bus initiator.
// It watches the CPU bus for a write to TRIGGER_ADDR and latches the written
// byte as the source page. It then requests the system bus and copies
// XFER_LEN bytes. Each byte is a read from {page, idx} followed by a write
// to OAM_DATA_ADDR. Each byte takes three cycles (RD, WAIT, WR). The WAIT
// cycle covers the decoder's one-cycle registered read.
// If bus_grant drops, the current state is frozen and then re-executed
// in full when the grant returns.
// Optional build macro DMA_ALIGN_EN inserts a one- or two-cycle ALIGN phase
// after the grant. The length depends on a free-running parity flop.
module oam_dma_master #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] snoop_addr,
  input  logic [7:0]  snoop_data,
  input  logic        snoop_write_en,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  input  logic [7:0]  dma_data_in,
  output logic        dma_write_en,
  output logic        dma_read_en,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
`ifdef DMA_ALIGN_EN
    S_ALIGN,
`endif
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_latch;

  logic trigger;
  logic capture;
  logic advance;

`ifdef DMA_ALIGN_EN
  logic parity;
  logic align_second;

  // Free-running parity; also remembers whether the extra ALIGN cycle is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity       <= 1'b0;
      align_second <= 1'b0;
    end else begin
      parity <= ~parity;
      if (state == S_ALIGN && bus_grant)
        align_second <= parity && !align_second;
    end
  end
`endif

  // State register.
  // NOTE: every flop is written with <= so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Source page, byte index and read-data latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      page       <= 8'h00;
      idx        <= 8'h00;
      data_latch <= 8'h00;
    end else begin
      if (trigger) begin
        page <= snoop_data;
        idx  <= 8'h00;
      end
      if (capture) data_latch <= dma_data_in;
      if (advance) idx <= idx + 8'd1;
    end
  end

  // Next state, bus outputs and datapath enables. The strobes are gated by the grant.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    state_next   = state;
    bus_req      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    dma_addr     = 16'h0000;
    dma_data_out = 8'h00;
    dma_read_en  = 1'b0;
    dma_write_en = 1'b0;
    trigger      = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;

    case (state)
      S_IDLE: begin
        if (snoop_write_en && snoop_addr == TRIGGER_ADDR) begin
          trigger    = 1'b1;
          state_next = S_REQ;
        end
      end

      S_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_grant) begin
`ifdef DMA_ALIGN_EN
          state_next = S_ALIGN;
`else
          state_next = S_RD;
`endif
        end
      end

`ifdef DMA_ALIGN_EN
      S_ALIGN: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        // Odd parity on the first ALIGN cycle adds a second one.
        if (bus_grant && !(parity && !align_second))
          state_next = S_RD;
      end
`endif

      S_RD: begin
        bus_req     = 1'b1;
        busy        = 1'b1;
        dma_addr    = {page, idx};
        dma_read_en = bus_grant;
        if (bus_grant) state_next = S_WAIT;
      end

      S_WAIT: begin
        bus_req  = 1'b1;
        busy     = 1'b1;
        dma_addr = {page, idx};
        // Capture only on a granted WAIT. A stalled WAIT repeats and captures later.
        capture  = bus_grant;
        if (bus_grant) state_next = S_WR;
      end

      S_WR: begin
        bus_req      = 1'b1;
        busy         = 1'b1;
        dma_addr     = OAM_DATA_ADDR;
        dma_data_out = data_latch;
        dma_write_en = bus_grant;
        if (bus_grant) begin
          if (idx == LAST_IDX) begin
            state_next = S_DONE;
          end else begin
            advance    = 1'b1;
            state_next = S_RD;
          end
        end
      end

      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_master.sv
// tb_oam_dma_master: directed and randomized bench for oam_dma_master.
// A CPU memory array answers reads with a one-cycle registered latency.
// Expected OAM writes for a page are the 256 bytes mem[{page, i}], taken in order.
// The bus monitor samples DUT outputs on the falling edge.
module tb_oam_dma_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] snoop_addr;
  logic [7:0]  snoop_data;
  logic        snoop_write_en;
  logic        bus_req;
  logic        bus_grant = 1'b0;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic [7:0]  dma_data_in = 8'h00;
  logic        dma_write_en;
  logic        dma_read_en;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  oam_dma_master dut (
    .clk            (clk),
    .rst            (rst),
    .snoop_addr     (snoop_addr),
    .snoop_data     (snoop_data),
    .snoop_write_en (snoop_write_en),
    .bus_req        (bus_req),
    .bus_grant      (bus_grant),
    .dma_addr       (dma_addr),
    .dma_data_out   (dma_data_out),
    .dma_data_in    (dma_data_in),
    .dma_write_en   (dma_write_en),
    .dma_read_en    (dma_read_en),
    .busy           (busy),
    .done           (done)
  );

  // CPU memory model and bus observation records.
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          cyc = 0;
  int          busy_total = 0;
  int          done_total = 0;
  int          strobe_viol = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_pend_addr = 16'h0000;

  // Grant control: 0 = always granted, 1 = random drops, 2 = 5-cycle drop in WAIT of byte 17.
  int gmode = 0;
  int drop_base = 0;
  int drop_left = 0;
  bit drop_armed = 1'b0;

  int compared = 0;
  int mismatched = 0;

  // Falling-edge monitor: records strobes, counts busy/done and drives bus_grant.
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_total++;
    if (done) done_total++;
    if ((dma_read_en || dma_write_en) && !bus_grant) strobe_viol++;
    rd_pend      = dma_read_en;
    rd_pend_addr = dma_addr;
    if (dma_read_en) rd_q.push_back(dma_addr);
    if (dma_write_en) begin
      wr_addr_q.push_back(dma_addr);
      wr_data_q.push_back(dma_data_out);
    end
    case (gmode)
      1: bus_grant = ($urandom_range(0, 3) != 0);
      2: begin
        if (drop_left > 0) begin
          bus_grant = 1'b0;
          drop_left--;
        end else if (drop_armed) begin
          bus_grant  = 1'b0;
          drop_left  = 4;
          drop_armed = 1'b0;
        end else begin
          bus_grant = 1'b1;
        end
        if (dma_read_en && rd_q.size() == drop_base + 18) drop_armed = 1'b1;
      end
      default: bus_grant = 1'b1;
    endcase
  end

  // Registered read port of the memory.
  always @(posedge clk) begin
    if (rd_pend) dma_data_in <= mem[rd_pend_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    snoop_addr     = a;
    snoop_data     = d;
    snoop_write_en = 1'b1;
    @(negedge clk); #1;
    snoop_write_en = 1'b0;
    snoop_addr     = 16'h0000;
    snoop_data     = 8'h00;
  endtask

  // One full transfer from trigger to done, then a check of the full read/write trace.
  task automatic run_xfer(input logic [7:0] page, input int mode, input string tag,
                          input bit retrig, input bit trig_at_done, output int busy_cnt);
    int rb, wb, bb, db, vb, n, nr, nw, bad_rd, bad_wa, bad_wd;
    bit rt;
    rb = rd_q.size(); wb = wr_data_q.size();
    bb = busy_total;  db = done_total; vb = strobe_viol;
    drop_base = rb;
    gmode = mode;
    cpu_write(16'h4014, page);
    n = 0; rt = 1'b0;
    while (done_total == db && n < 6000) begin
      @(negedge clk); #1;
      n++;
      if (snoop_write_en) snoop_write_en = 1'b0;
      if (retrig && !rt && rd_q.size() >= rb + 101) begin
        snoop_addr = 16'h4014; snoop_data = 8'h05; snoop_write_en = 1'b1; rt = 1'b1;
      end
    end
    check({tag, " completes"}, 32'(n < 6000), 32'd1);
    if (trig_at_done) begin
      // A trigger during the DONE cycle must be ignored.
      snoop_addr = 16'h4014; snoop_data = 8'h07; snoop_write_en = 1'b1;
    end
    @(negedge clk); #1;
    snoop_write_en = 1'b0;
    gmode = 0;
    repeat (4) @(negedge clk);
    #1;
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " bus_req after"}, 32'(bus_req), 32'd0);
    check({tag, " done pulses"}, 32'(done_total - db), 32'd1);
    nr = rd_q.size() - rb;
    nw = wr_data_q.size() - wb;
    check({tag, " read count"}, 32'(nr), 32'd256);
    check({tag, " write count"}, 32'(nw), 32'd256);
    check({tag, " strobes without grant"}, 32'(strobe_viol - vb), 32'd0);
    bad_rd = 0; bad_wa = 0; bad_wd = 0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] src;
      src = {page, 8'(i)};
      if (i < nr && rd_q[rb + i] !== src) bad_rd++;
      if (i < nw && wr_addr_q[wb + i] !== 16'h2004) bad_wa++;
      if (i < nw && wr_data_q[wb + i] !== mem[src]) bad_wd++;
    end
    check({tag, " read addr errors"}, 32'(bad_rd), 32'd0);
    check({tag, " write addr errors"}, 32'(bad_wa), 32'd0);
    check({tag, " write data errors"}, 32'(bad_wd), 32'd0);
    busy_cnt = busy_total - bb;
  endtask

  initial begin
    int bcnt, n, rb;
    logic [7:0] pg;
`ifdef DMA_ALIGN_EN
    int c1, b1, b2;
`endif
    rst = 1'b0;
    snoop_addr = 16'h0000; snoop_data = 8'h00; snoop_write_en = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int a = 16'h0200; a <= 16'h02FF; a++) mem[a] = ~8'(a);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("reset bus_req", 32'(bus_req), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset strobes", 32'({dma_read_en, dma_write_en}), 32'd0);
    check("reset dma_addr", 32'(dma_addr), 32'd0);
    check("reset dma_data_out", 32'(dma_data_out), 32'd0);
    rst = 1'b1;

    // Non-trigger write leaves the block idle.
    cpu_write(16'h4015, 8'h02);
    repeat (10) @(negedge clk);
    #1;
    check("non-trigger bus_req", 32'(bus_req), 32'd0);
    check("non-trigger busy", 32'(busy), 32'd0);

    // Basic transfer of page 0x02 (bytes 0xFF down to 0x00), with a trigger in the DONE cycle.
    run_xfer(8'h02, 0, "basic", 1'b0, 1'b1, bcnt);
    check("basic first byte", 32'(wr_data_q[wr_data_q.size() - 256]), 32'hFF);
    check("basic last byte", 32'(wr_data_q[wr_data_q.size() - 1]), 32'h00);
`ifndef DMA_ALIGN_EN
    // REQ (1) + 256 * 3 + DONE (1).
    check("basic busy cycles", 32'(bcnt), 32'd770);
`endif

    // Grant dropped for 5 cycles during WAIT of byte 17.
    run_xfer(8'h02, 2, "grant drop", 1'b0, 1'b0, bcnt);
`ifndef DMA_ALIGN_EN
    check("grant drop busy cycles", 32'(bcnt), 32'd775);
`endif

    // Retrigger with 0x05 while busy at byte 100.
    run_xfer(8'h02, 0, "retrigger", 1'b1, 1'b0, bcnt);

    // Reset at byte 50.
    rb = rd_q.size();
    cpu_write(16'h4014, 8'h02);
    n = 0;
    while (rd_q.size() < rb + 51 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("reach byte 50", 32'(n < 2000), 32'd1);
    rst = 1'b0;
    @(negedge clk); #1;
    check("mid reset bus_req", 32'(bus_req), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset write_en", 32'(dma_write_en), 32'd0);
    check("mid reset read_en", 32'(dma_read_en), 32'd0);
    check("mid reset dma_addr", 32'(dma_addr), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("after reset idle", 32'({busy, bus_req}), 32'd0);
    run_xfer(8'h03, 0, "post reset", 1'b0, 1'b0, bcnt);

    // Randomized pages (first one in the register region) with random grant drops.
    for (int k = 0; k < 3; k++) begin
      pg = (k == 0) ? 8'($urandom_range(32, 63)) : 8'($urandom_range(0, 255));
      run_xfer(pg, 1, $sformatf("random page %0h", pg), 1'b0, 1'b0, bcnt);
    end

`ifdef DMA_ALIGN_EN
    // Two transfers triggered on opposite parity phases: one and two ALIGN cycles.
    c1 = cyc;
    run_xfer(8'h02, 0, "align a", 1'b0, 1'b0, b1);
    if (((cyc - c1) % 2) == 0) begin
      @(negedge clk); #1;
    end
    run_xfer(8'h02, 0, "align b", 1'b0, 1'b0, b2);
    check("align min busy", 32'((b1 < b2) ? b1 : b2), 32'd771);
    check("align max busy", 32'((b1 < b2) ? b2 : b1), 32'd772);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/oam_dma_master.md
Name: oam_dma_master

Overview:
- Bus initiator for sprite OAM DMA.
- Snoops the CPU bus for a write to 0x4014 and latches the written value as the source page.
- Requests the system bus, then issues 256 read/write pairs: read from page:idx in CPU memory, write to 0x2004 (SPRAM data port). The decoder's SPRAM address auto-increments on each 0x2004 write.
- Sits beside the CPU on the system controller's bus mux, feeding the memory decoder's CPU-side port.

Parameters:
- TRIGGER_ADDR, 16'h4014, snooped address that starts a DMA.
- OAM_DATA_ADDR, 16'h2004, destination register address.
- XFER_LEN, 256, bytes per transfer; must be a power of two, max 256.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- snoop_addr  in  16  CPU address bus
- snoop_data  in  8  CPU write data
- snoop_write_en  in  1  CPU write strobe
- bus_req  out  1  request for bus ownership (stalls CPU)
- bus_grant  in  1  system controller grants the bus; may drop at any cycle
- dma_addr  out  16  address driven to the memory decoder
- dma_data_out  out  8  write data to the decoder
- dma_data_in  in  8  decoder read data (decoder cpu_data_out)
- dma_write_en  out  1  write strobe
- dma_read_en  out  1  read strobe
- busy  out  1  high from trigger until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset values:
  - All outputs 0; dma_addr = 0.
  - State IDLE; page = 0; idx = 0; data latch = 0.
- Trigger:
  - Condition: state IDLE, snoop_write_en = 1 and snoop_addr == TRIGGER_ADDR.
  - On the next edge: page <= snoop_data, idx <= 0, state -> REQ, busy = 1.
  - Triggers outside IDLE are ignored; the page is not updated.
- States:
  - IDLE
  - REQ: bus_req = 1; strobes low; wait for bus_grant.
  - ALIGN: only when DMA_ALIGN_EN is defined.
  - RD:
    - dma_addr = {page, idx}, dma_read_en = 1.
    - Next state WAIT.
  - WAIT:
    - dma_addr held, read_en = 0.
    - Decoder memory has a 1-cycle registered read; dma_data_in is captured into the data latch at the end of WAIT.
    - Next state WR.
  - WR:
    - dma_addr = OAM_DATA_ADDR, dma_data_out = latch, dma_write_en = 1.
    - If idx == XFER_LEN-1, next state DONE; otherwise idx <= idx+1 and next state RD.
  - DONE:
    - done = 1 for one cycle; bus_req = 0; busy = 0 from the next cycle.
    - Next state IDLE.
- Throughput: 3 cycles per byte. Without alignment, a 256-byte transfer takes 768 cycles from first RD to last WR.
- bus_req stays high from REQ through the last WR.
- Strobes are combinational from state and are asserted only while bus_grant = 1.
- Grant loss (bus_grant low in RD, WAIT, WR or ALIGN):
  - State, idx and latch are frozen; strobes forced 0.
  - When grant returns, the same state is re-executed in full.
  - If grant drops during WAIT, WAIT repeats so the latch captures valid data.
  - No byte is skipped or duplicated.
- Width rules:
  - idx is 8 bits and wraps modulo 256; the wrap is never observable because the transfer ends at 255.
  - dma_addr high byte = page; no carry into page.
- Page 0x20–0x3F: a source in the register region is allowed with no special handling; the decoder returns its register values.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A partial OAM update is left as written.
- Simultaneous trigger and DONE: the trigger is ignored because the state is not IDLE.

Optional Feature:
- Macro: DMA_ALIGN_EN
- When defined:
  - A free-running parity flop toggles every clk.
  - After the first granted cycle in REQ, the FSM enters ALIGN for 1 cycle, plus 1 more if parity = 1 at ALIGN entry.
  - This gives 769/770 cycles from grant to done, matching console 513/514-style alignment.
- When undefined: the ALIGN state and parity flop are absent; REQ with grant goes directly to RD.

Test Plan:
- Basic transfer:
  - Stimulus: preload CPU mem 0x0200–0x02FF with value = ~addr[7:0]; write 0x02 to 0x4014; grant held high.
  - Required: 256 writes to 0x2004 carrying 0xFF, 0xFE, … 0x00 in order; done pulses once; busy high for exactly 768 + REQ cycles.
- Grant toggle:
  - Stimulus: drop bus_grant for 5 cycles at byte 17, during WAIT.
  - Required: no strobes while grant is low; byte 17 written once with the correct value; total write count 256.
- Retrigger while busy:
  - Stimulus: snooped write of 0x05 to 0x4014 at byte 100 of a page-0x02 transfer.
  - Required: ignored; all reads stay in 0x02xx.
- Reset mid-transfer:
  - Stimulus: rst low at byte 50.
  - Required: next cycle bus_req = busy = dma_write_en = 0, state IDLE.
  - Then: a new trigger with 0x03 transfers from 0x0300.
- Alignment (DMA_ALIGN_EN defined):
  - Stimulus: trigger on even-parity and odd-parity cycles.
  - Required: grant-to-done = 769 and 770 cycles respectively.
- Non-trigger write:
  - Stimulus: write to 0x4015.
  - Required: no bus_req; state remains IDLE.
